bist_alu_controller: RTL and testbench

Sequencing controller for the ALU built-in self-test datapath (pattern generators A/B, ALU, golden-signature ROM, comparator).
- On start, walks every enabled ALU opcode. For each one it drives ALU_Sel, restarts the pattern generators and ROM address counter, and samples the comparator match line for a fixed number of patterns.
- Accumulates a failure count and the first failing (opcode, pattern index).
- Reports done and pass/fail to the top-level test harness.

---
 rtl/bist_ctrl_pkg.sv | 18 +
 rtl/bist_next_op.sv | 27 ++
 rtl/bist_alu_controller.sv | 151 +++++++++++++++
 tb/tb_bist_alu_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/bist_ctrl_pkg.sv
// Shared types and default sizing for the ALU BIST sequencing controller.
package bist_ctrl_pkg;

  localparam int unsigned BIST_NUM_OPS         = 16;
  localparam int unsigned BIST_PATTERNS_PER_OP = 16;
  localparam int unsigned BIST_SEL_W           = 4;
  localparam int unsigned BIST_IDX_W           = 8;
  localparam int unsigned BIST_CNT_W           = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_RUN  = 3'd2,
    ST_NEXT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/bist_next_op.sv
// Priority encoder: lowest enabled opcode, or lowest one strictly above cur_sel.
module bist_next_op
  import bist_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OPS = BIST_NUM_OPS,
  parameter int unsigned SEL_W   = BIST_SEL_W
) (
  input  logic [NUM_OPS-1:0] mask,
  input  logic [SEL_W-1:0]   cur_sel,
  input  logic               first,
  output logic [SEL_W-1:0]   next_sel_c,
  output logic               found_c
);

  // Scan downwards so the lowest qualifying opcode wins.
  always_comb begin
    next_sel_c = '0;
    found_c    = 1'b0;
    for (int i = int'(NUM_OPS) - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur_sel)))) begin
        next_sel_c = SEL_W'(i);
        found_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_alu_controller.sv
// Walks every enabled ALU opcode, restarts the pattern sources per opcode and
// accumulates comparator mismatches into a saturating count plus first-fail info.
module bist_alu_controller
  import bist_ctrl_pkg::*;
#(
  parameter int unsigned NUM_OPS         = BIST_NUM_OPS,
  parameter int unsigned PATTERNS_PER_OP = BIST_PATTERNS_PER_OP,
  parameter int unsigned SEL_W           = BIST_SEL_W,
  parameter int unsigned IDX_W           = BIST_IDX_W,
  parameter int unsigned CNT_W           = BIST_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_OPS-1:0] op_mask,
  input  logic               match,
  output logic [SEL_W-1:0]   alu_sel,
  output logic               gen_reset,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   fail_count,
  output logic [SEL_W-1:0]   first_fail_sel,
  output logic [IDX_W-1:0]   first_fail_idx
);

  state_t             state, state_nxt;
  logic [NUM_OPS-1:0] mask_q, mask_nxt;
  logic [IDX_W-1:0]   pat_idx, pat_idx_nxt;
  logic [SEL_W-1:0]   alu_sel_nxt, first_fail_sel_nxt;
  logic [IDX_W-1:0]   first_fail_idx_nxt;
  logic [CNT_W-1:0]   fail_count_nxt;
  logic               gen_reset_nxt, busy_nxt, done_nxt, pass_nxt;

  logic               idle_like;
  logic               last_pat;
  logic               enc_first;
  logic [NUM_OPS-1:0] enc_mask;
  logic [SEL_W-1:0]   enc_sel;
  logic               enc_found;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign last_pat  = (pat_idx == IDX_W'(PATTERNS_PER_OP - 1));

  // Idle: pick the first opcode of the incoming mask; running: step past alu_sel.
  assign enc_first = idle_like;
  assign enc_mask  = idle_like ? op_mask : mask_q;

  bist_next_op #(
    .NUM_OPS (NUM_OPS),
    .SEL_W   (SEL_W)
  ) u_next_op (
    .mask       (enc_mask),
    .cur_sel    (alu_sel),
    .first      (enc_first),
    .next_sel_c (enc_sel),
    .found_c    (enc_found)
  );

  // State and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      mask_q         <= '0;
      pat_idx        <= '0;
      alu_sel        <= '0;
      gen_reset      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= '0;
      first_fail_sel <= '0;
      first_fail_idx <= '0;
    end else begin
      state          <= state_nxt;
      mask_q         <= mask_nxt;
      pat_idx        <= pat_idx_nxt;
      alu_sel        <= alu_sel_nxt;
      gen_reset      <= gen_reset_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      pass           <= pass_nxt;
      fail_count     <= fail_count_nxt;
      first_fail_sel <= first_fail_sel_nxt;
      first_fail_idx <= first_fail_idx_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT;
      ST_INIT:          state_nxt = (mask_q == '0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (last_pat) state_nxt = enc_found ? ST_NEXT : ST_DONE;
      ST_NEXT:          state_nxt = ST_RUN;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    mask_nxt           = mask_q;
    pat_idx_nxt        = pat_idx;
    alu_sel_nxt        = alu_sel;
    busy_nxt           = busy;
    done_nxt           = done;
    pass_nxt           = pass;
    fail_count_nxt     = fail_count;
    first_fail_sel_nxt = first_fail_sel;
    first_fail_idx_nxt = first_fail_idx;
    gen_reset_nxt      = (state_nxt == ST_INIT) || (state_nxt == ST_NEXT);

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mask_nxt           = op_mask;
          alu_sel_nxt        = enc_sel;
          fail_count_nxt     = '0;
          first_fail_sel_nxt = '0;
          first_fail_idx_nxt = '0;
          pass_nxt           = 1'b0;
          busy_nxt           = 1'b1;
          done_nxt           = 1'b0;
        end
      end
      ST_INIT: pat_idx_nxt = '0;
      ST_RUN: begin
        pat_idx_nxt = pat_idx + IDX_W'(1);
        if (!match) begin
          if (fail_count != '1) fail_count_nxt = fail_count + CNT_W'(1);
          // A zero count means no mismatch has been seen yet in this run.
          if (fail_count == '0) begin
            first_fail_sel_nxt = alu_sel;
            first_fail_idx_nxt = pat_idx;
          end
        end
        if (last_pat && enc_found) alu_sel_nxt = enc_sel;
      end
      ST_NEXT: pat_idx_nxt = '0;
      default: ;
    endcase

    if ((state_nxt == ST_DONE) && (state != ST_DONE)) begin
      busy_nxt = 1'b0;
      done_nxt = 1'b1;
      pass_nxt = (fail_count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_bist_alu_controller.sv
// Directed bench for bist_alu_controller with a small pattern-index model driving match.
module tb_bist_alu_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] op_mask;
  logic        match;
  logic [3:0]  alu_sel;
  logic        gen_reset;
  logic        busy;
  logic        done;
  logic        pass;
  logic [7:0]  fail_count;
  logic [3:0]  first_fail_sel;
  logic [7:0]  first_fail_idx;

  int          n_vec  = 0;
  int          n_miss = 0;
  int          mode   = 0;
  int          tb_idx = 0;
  int          lat, ngr, bad;
  logic [15:0] seen;
  int          sel_seq[$];

  bist_alu_controller dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .op_mask        (op_mask),
    .match          (match),
    .alu_sel        (alu_sel),
    .gen_reset      (gen_reset),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fail_count     (fail_count),
    .first_fail_sel (first_fail_sel),
    .first_fail_idx (first_fail_idx)
  );

  always #5 clk = ~clk;

  // Model of the ROM address counter restarted by gen_reset.
  always @(posedge clk) tb_idx <= gen_reset ? 0 : tb_idx + 1;

  always_comb begin
    case (mode)
      0:       match = 1'b1;
      1:       match = !(((alu_sel == 4'd3) && (tb_idx == 5)) ||
                         ((alu_sel == 4'd9) && (tb_idx == 0)));
      default: match = 1'b0;
    endcase
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] mask);
    @(negedge clk);
    op_mask = mask;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Runs one BIST pass, recording latency, gen_reset pulses, opcode order and coverage.
  task automatic do_run(input logic [15:0] mask, input int inject_at);
    int         cyc;
    logic [3:0] prev;
    pulse_start(mask);
    check_val("e0_busy", 32'(busy), 32'd1);
    check_val("e0_done", 32'(done), 32'd0);
    check_val("e0_fail_count", 32'(fail_count), 32'd0);
    cyc  = 0;
    ngr  = 0;
    bad  = 0;
    seen = '0;
    sel_seq.delete();
    prev = alu_sel;
    forever begin
      if (gen_reset) begin
        ngr++;
        sel_seq.push_back(int'(alu_sel));
      end else if (alu_sel != prev) begin
        bad++;
      end
      prev          = alu_sel;
      seen[alu_sel] = 1'b1;
      if (done || cyc >= 2000) break;
      if (cyc == inject_at) begin
        start   = 1'b1;
        op_mask = 16'h0001;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start = 1'b0;
    lat   = done ? cyc : -1;
  endtask

  task automatic check_full_seq();
    check_val("seq_len", 32'(sel_seq.size()), 32'd16);
    for (int i = 0; i < sel_seq.size() && i < 16; i++)
      check_val("seq_val", 32'(sel_seq[i]), 32'(i));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    op_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_alu_sel", 32'(alu_sel), 32'd0);
    check_val("rst_gen_reset", 32'(gen_reset), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_pass", 32'(pass), 32'd0);
    check_val("rst_fail_count", 32'(fail_count), 32'd0);
    check_val("rst_ffs", 32'(first_fail_sel), 32'd0);
    check_val("rst_ffi", 32'(first_fail_idx), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // All opcodes, clean compare.
    mode = 0;
    do_run(16'hFFFF, -1);
    check_val("t1_latency", 32'(lat), 32'd272);
    check_val("t1_gen_reset_pulses", 32'(ngr), 32'd16);
    check_val("t1_sel_glitch", 32'(bad), 32'd0);
    check_val("t1_seen", 32'(seen), 32'hFFFF);
    check_full_seq();
    check_val("t1_pass", 32'(pass), 32'd1);
    check_val("t1_fail_count", 32'(fail_count), 32'd0);
    check_val("t1_busy", 32'(busy), 32'd0);

    // Two planted mismatches.
    mode = 1;
    do_run(16'hFFFF, -1);
    check_val("t2_fail_count", 32'(fail_count), 32'd2);
    check_val("t2_ffs", 32'(first_fail_sel), 32'd3);
    check_val("t2_ffi", 32'(first_fail_idx), 32'd5);
    check_val("t2_pass", 32'(pass), 32'd0);

    // Sparse mask: opcodes 0 and 2 only.
    mode = 0;
    do_run(16'h0005, -1);
    check_val("t3_latency", 32'(lat), 32'd34);
    check_val("t3_seq_len", 32'(sel_seq.size()), 32'd2);
    if (sel_seq.size() == 2) begin
      check_val("t3_seq0", 32'(sel_seq[0]), 32'd0);
      check_val("t3_seq1", 32'(sel_seq[1]), 32'd2);
    end
    check_val("t3_seen", 32'(seen), 32'h0005);
    check_val("t3_pass", 32'(pass), 32'd1);

    // Empty mask.
    do_run(16'h0000, -1);
    check_val("t4_latency", 32'(lat), 32'd1);
    check_val("t4_gen_reset_pulses", 32'(ngr), 32'd1);
    check_val("t4_pass", 32'(pass), 32'd1);
    check_val("t4_fail_count", 32'(fail_count), 32'd0);

    // Every sample fails: counter saturates.
    mode = 2;
    do_run(16'hFFFF, -1);
    check_val("t5_latency", 32'(lat), 32'd272);
    check_val("t5_fail_count", 32'(fail_count), 32'd255);
    check_val("t5_ffs", 32'(first_fail_sel), 32'd0);
    check_val("t5_ffi", 32'(first_fail_idx), 32'd0);
    check_val("t5_pass", 32'(pass), 32'd0);

    // Abort mid-run with reset while opcode 6 is under test.
    mode = 0;
    pulse_start(16'hFFFF);
    repeat (110) @(posedge clk);
    #1;
    check_val("t6_mid_sel", 32'(alu_sel), 32'd6);
    check_val("t6_mid_busy", 32'(busy), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_val("t6_abort_sel", 32'(alu_sel), 32'd0);
    check_val("t6_abort_busy", 32'(busy), 32'd0);
    check_val("t6_abort_done", 32'(done), 32'd0);
    check_val("t6_abort_gen_reset", 32'(gen_reset), 32'd0);
    check_val("t6_abort_fail_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("t6_idle_busy", 32'(busy), 32'd0);
    check_val("t6_idle_gen_reset", 32'(gen_reset), 32'd0);

    // Faulty run with a start pulse injected mid-run, which must be ignored.
    mode = 1;
    do_run(16'hFFFF, 40);
    check_val("t6_latency", 32'(lat), 32'd272);
    check_val("t6_gen_reset_pulses", 32'(ngr), 32'd16);
    check_full_seq();
    check_val("t6_fail_count", 32'(fail_count), 32'd2);
    check_val("t6_ffs", 32'(first_fail_sel), 32'd3);

    // Restart from DONE clears the previous results.
    mode = 0;
    do_run(16'h0005, -1);
    check_val("t6_rerun_latency", 32'(lat), 32'd34);
    check_val("t6_rerun_fail_count", 32'(fail_count), 32'd0);
    check_val("t6_rerun_ffs", 32'(first_fail_sel), 32'd0);
    check_val("t6_rerun_ffi", 32'(first_fail_idx), 32'd0);
    check_val("t6_rerun_pass", 32'(pass), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
